watermark_pixel_collector: RTL and testbench



---
 rtl/watermark_pixel_collector.sv | 152 +++++++++++++++
 tb/tb_watermark_pixel_collector.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/watermark_pixel_collector.sv
// Packs watermarked pixels in pairs into APB-wide words, buffers them in a FIFO
// and exposes STATUS/DATA/CTRL registers plus an image-complete/overflow interrupt.
module watermark_pixel_collector #(
    parameter int Data_Depth      = 8,
    parameter int amba_word       = 16,
    parameter int amba_addr_depth = 20,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       new_pixel,
    input  logic [Data_Depth-1:0]      Pixel_Data,
    input  logic                       Image_Done,
    input  logic                       PSEL,
    input  logic                       PENABLE,
    input  logic                       PWRITE,
    input  logic [amba_addr_depth-1:0] PADDR,
    input  logic [amba_word-1:0]       PWDATA,
    output logic [amba_word-1:0]       PRDATA,
    output logic                       irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {LOW, HIGH} state_t;

    state_t                state_q, state_d;
    logic [Data_Depth-1:0] low_q, low_d;
    logic [amba_word-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  img_q, img_d, ovf_q, ovf_d, irq_en_q, irq_en_d, irq_q, irq_d;

    logic                  access, pop, ctrl_wr, flush, ack, empty, full;
    logic                  push, do_push, set_done;
    logic [amba_word-1:0]  push_word, status;
    logic                  unused_bits;

    assign unused_bits = ^{PADDR[amba_addr_depth-1:2], PWDATA[amba_word-1:3]};

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign access  = PSEL & PENABLE;
    assign pop     = access & ~PWRITE & (PADDR[1:0] == 2'd1) & ~empty;
    assign ctrl_wr = access & PWRITE & (PADDR[1:0] == 2'd2);
    assign flush   = ctrl_wr & PWDATA[0];
    assign ack     = ctrl_wr & PWDATA[2];

    // Pixel is packed first; the end-of-image flush then acts on the resulting state.
    always_comb begin
        state_d   = state_q;
        low_d     = low_q;
        push      = 1'b0;
        push_word = '0;
        set_done  = 1'b0;
        if (new_pixel) begin
            if (state_q == LOW) begin
                low_d   = Pixel_Data;
                state_d = HIGH;
            end else begin
                push                         = 1'b1;
                push_word[2*Data_Depth-1:0]  = {Pixel_Data, low_q};
                state_d                      = LOW;
            end
        end
        if (Image_Done) begin
            set_done = 1'b1;
            if (state_d == HIGH && !push) begin
                push                       = 1'b1;
                push_word[Data_Depth-1:0]  = low_d;
                state_d                    = LOW;
            end
        end
        if (flush) begin
            state_d = LOW;
        end
    end

    // A push into a full FIFO only lands when a pop frees the slot that same edge.
    always_comb begin
        do_push  = push & (~full | pop) & ~flush;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(do_push) - CW'(pop);
        img_d    = img_q;
        ovf_d    = ovf_q;
        if (ack) begin
            img_d = 1'b0;
            ovf_d = 1'b0;
        end
        if (set_done) img_d = 1'b1;
        if (push && full && !pop) ovf_d = 1'b1;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            img_d    = 1'b0;
            ovf_d    = 1'b0;
        end
        irq_en_d = ctrl_wr ? PWDATA[1] : irq_en_q;
        irq_d    = irq_en_q & (img_q | ovf_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= LOW;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            img_q    <= 1'b0;
            ovf_q    <= 1'b0;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            img_q    <= img_d;
            ovf_q    <= ovf_d;
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    always_ff @(posedge clk) begin
        low_q <= low_d;
        if (do_push) mem_q[wr_ptr_q] <= push_word;
    end

    always_comb begin
        status          = '0;
        status[CW-1:0]  = count_q;
        status[8]       = empty;
        status[9]       = full;
        status[10]      = img_q;
        status[11]      = ovf_q;
        status[12]      = (state_q == HIGH);
        PRDATA          = '0;
        if (PSEL && !PWRITE) begin
            case (PADDR[1:0])
                2'd0:    PRDATA = status;
                2'd1:    PRDATA = empty ? '0 : mem_q[rd_ptr_q];
                default: PRDATA = '0;
            endcase
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_watermark_pixel_collector.sv
// Scoreboard bench for watermark_pixel_collector: expected words are queued as
// pixels are driven and compared as DATA reads drain the FIFO.
module tb_watermark_pixel_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        new_pixel, Image_Done, PSEL, PENABLE, PWRITE;
    logic [7:0]  Pixel_Data;
    logic [19:0] PADDR;
    logic [15:0] PWDATA, PRDATA;
    logic        irq;

    int total = 0;
    int bad   = 0;

    logic [15:0] sb[$];
    bit          m_high = 0;
    logic [7:0]  m_low  = 8'h00;

    watermark_pixel_collector dut (
        .clk(clk), .rst(rst), .new_pixel(new_pixel), .Pixel_Data(Pixel_Data),
        .Image_Done(Image_Done), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_push(input logic [15:0] w);
        if (sb.size() < 16) sb.push_back(w);
    endfunction

    function automatic void m_pixel(input logic [7:0] p);
        if (!m_high) begin
            m_low  = p;
            m_high = 1;
        end else begin
            m_push({p, m_low});
            m_high = 0;
        end
    endfunction

    task automatic pix(input logic [7:0] p);
        @(negedge clk); new_pixel = 1'b1; Pixel_Data = p;
        @(negedge clk); new_pixel = 1'b0;
        m_pixel(p);
    endtask

    task automatic img_done();
        @(negedge clk); Image_Done = 1'b1;
        @(negedge clk); Image_Done = 1'b0;
        if (m_high) m_push({8'h00, m_low});
        m_high = 0;
    endtask

    task automatic apb_rd(input logic [1:0] a, output logic [15:0] d,
                          input logic px_en, input logic [7:0] px);
        @(negedge clk); PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = {18'h0, a};
        @(negedge clk); PENABLE = 1'b1; new_pixel = px_en; Pixel_Data = px;
        #1 d = PRDATA;
        @(negedge clk); PSEL = 1'b0; PENABLE = 1'b0; new_pixel = 1'b0;
    endtask

    task automatic apb_wr(input logic [1:0] a, input logic [15:0] d);
        @(negedge clk); PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = {18'h0, a}; PWDATA = d;
        @(negedge clk); PENABLE = 1'b1;
        @(negedge clk); PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        if (a == 2'd2 && d[0]) begin
            sb.delete();
            m_high = 0;
        end
    endtask

    task automatic rd_status(input string tag, input logic [15:0] exp);
        logic [15:0] d;
        apb_rd(2'd0, d, 1'b0, 8'h00);
        chk(tag, d, exp);
    endtask

    task automatic rd_data(input string tag);
        logic [15:0] d, exp;
        apb_rd(2'd1, d, 1'b0, 8'h00);
        exp = (sb.size() != 0) ? sb.pop_front() : 16'h0000;
        chk(tag, d, exp);
    endtask

    initial begin
        logic [15:0] d, exp;
        rst = 1'b0; new_pixel = 0; Image_Done = 0; PSEL = 0; PENABLE = 0; PWRITE = 0;
        Pixel_Data = 0; PADDR = 0; PWDATA = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // reset with irq_en set beforehand
        apb_wr(2'd2, 16'h0002);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        rst_check: begin
            rd_status("reset_status", 16'h0100);
            chk("reset_irq", irq, 1'b0);
        end

        // four pixels then end of image
        pix(8'h11); pix(8'h22); pix(8'h33); pix(8'h44);
        img_done();
        rd_status("even_status", 16'h0402);
        rd_data("even_w0"); rd_data("even_w1"); rd_data("even_empty");
        rd_status("even_drained", 16'h0500);
        apb_wr(2'd2, 16'h0004);
        rd_status("even_ack", 16'h0100);

        // odd pixel flush and interrupt timing
        apb_wr(2'd2, 16'h0002);
        pix(8'hAA); pix(8'hBB); pix(8'hCC);
        img_done();
        chk("odd_irq_early", irq, 1'b0);
        @(negedge clk);
        chk("odd_irq_rise", irq, 1'b1);
        rd_status("odd_status", 16'h0402);
        rd_data("odd_w0"); rd_data("odd_w1");
        apb_wr(2'd2, 16'h0006);
        @(negedge clk);
        chk("odd_irq_ack", irq, 1'b0);
        apb_wr(2'd2, 16'h0000);

        // full FIFO with pop coinciding with a completing pixel
        for (int i = 0; i < 33; i++) pix(8'(8'h40 + i));
        rd_status("full_pending", 16'h1210);
        apb_rd(2'd1, d, 1'b1, 8'hEE);
        exp = sb.pop_front();
        chk("full_pop_push", d, exp);
        m_pixel(8'hEE);
        rd_status("full_after", 16'h0210);
        for (int i = 0; i < 16; i++) rd_data($sformatf("full_drain%0d", i));
        rd_data("full_empty");

        // overflow: 17 words into a 16-deep FIFO
        for (int i = 0; i < 34; i++) pix(8'(i * 3 + 1));
        rd_status("ovf_status", 16'h0A10);
        for (int i = 0; i < 16; i++) rd_data($sformatf("ovf_drain%0d", i));
        rd_data("ovf_empty");
        rd_status("ovf_sticky", 16'h0900);
        apb_wr(2'd2, 16'h0004);

        // mid-stream flush
        pix(8'h01); pix(8'h02); pix(8'h03);
        rd_status("mid_status", 16'h1001);
        apb_wr(2'd2, 16'h0001);
        rd_status("mid_flushed", 16'h0100);
        pix(8'h55); pix(8'h66);
        rd_data("mid_word");
        rd_data("mid_empty");

        // asynchronous reset mid-image
        apb_wr(2'd2, 16'h0002);
        pix(8'h77); pix(8'h88); pix(8'h99);
        img_done();
        @(negedge clk);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 20'h0;
        #2 rst = 1'b0;
        #1;
        chk("arst_status", PRDATA, 16'h0100);
        chk("arst_irq", irq, 1'b0);
        PSEL = 1'b0;
        sb.delete();
        m_high = 0;
        @(negedge clk); rst = 1'b1;
        rd_status("arst_after", 16'h0100);
        rd_data("arst_data");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
